// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte stream -> 32-bit instruction memory words.
// Holds the core in reset until the whole image has been written.
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              Rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEN   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [32:0] CAP = 33'd1 << ADDR_W;

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  logic [31:0]       len;
  logic [ADDR_W:0]   word_cnt;
  logic [31:0]       len_nxt;
  logic [ADDR_W:0]   word_inc;
  logic              take;
  logic              last_word;

  assign take      = rx_valid && rx_ready;
  assign word_inc  = word_cnt + (ADDR_W+1)'(1);
  assign last_word = 32'(word_inc) == len;

  always_comb begin
    len_nxt = len;
    len_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      state      <= S_IDLE;
      byte_cnt   <= '0;
      len        <= '0;
      word_cnt   <= '0;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_LEN;
            byte_cnt   <= '0;
            word_cnt   <= '0;
            imem_addr  <= '0;
            rx_ready   <= 1'b1;
            core_rst_n <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
        S_LEN: begin
          if (take) begin
            len      <= len_nxt;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (len_nxt == 32'd0) begin
                state      <= S_DONE;
                rx_ready   <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
                core_rst_n <= 1'b1;
              end else if ({1'b0, len_nxt} > CAP) begin
                state    <= S_ERR;
                rx_ready <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b1;
              end else begin
                state <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (take) begin
            imem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= S_WRITE;
              rx_ready <= 1'b0;
              imem_we  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          imem_addr <= imem_addr + ADDR_W'(1);
          word_cnt  <= word_inc;
          if (last_word) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            core_rst_n <= 1'b1;
          end else begin
            state    <= S_DATA;
            rx_ready <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          rx_ready   <= 1'b0;
          core_rst_n <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: nominal, gaps, boundary lengths,
// restart and reset scenarios against hand-computed writes.
module tb_imem_loader;

  localparam int AW = 10;

  logic          CLK = 1'b0;
  logic          Rst = 1'b0;
  logic          start = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int viol = 0;
  bit gaps = 1'b0;
  logic          we_q = 1'b0;
  logic [AW-1:0] wr_addr [4096];
  logic [31:0]   wr_data [4096];

  imem_loader #(.ADDR_W(AW)) dut (
    .CLK(CLK), .Rst(Rst), .start(start),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  // write log plus strobe-shape monitor
  always @(posedge CLK) begin
    if (imem_we) begin
      wr_addr[wr_cnt % 4096] <= imem_addr;
      wr_data[wr_cnt % 4096] <= imem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    viol <= viol + int'(imem_we && we_q) + int'(imem_we && rx_ready);
    we_q <= imem_we;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        @(negedge CLK);
        rx_valid = 1'b0;
      end
    end
    @(negedge CLK);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: rx_ready=%b want 1", rx_ready);
      rx_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_start;
    @(negedge CLK);
    rx_valid = 1'b0;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    int base;
    logic [AW+38:0] outs;
    #3;
    outs = {rx_ready, imem_we, imem_addr, imem_wdata,
            core_rst_n, busy, done, err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL por_values: got %h want 0", outs);
    end
    @(negedge CLK);
    Rst = 1'b1;
    idle(3);
    checks++;
    if ({rx_ready, busy, done, err, core_rst_n} !== 5'b0) begin
      errors++;
      $display("FAIL idle_after_por: got %b want 00000",
               {rx_ready, busy, done, err, core_rst_n});
    end
    base = wr_cnt;
    do_start();
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h05);
    rx_valid = 1'b0;
    #1 Rst = 1'b0;
    #1;
    outs = {rx_ready, imem_we, imem_addr, imem_wdata,
            core_rst_n, busy, done, err};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL mid_data_reset: got %h want 0", outs);
    end
    @(negedge CLK);
    Rst = 1'b1;
    idle(5);
    checks++;
    if ({rx_ready, busy, core_rst_n, wr_cnt - base} !== {3'b000, 32'd0}) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b crst=%b writes=%0d want 0 0 0 0",
               rx_ready, busy, core_rst_n, wr_cnt - base);
    end
  endtask

  task automatic load_two(input string tag);
    int base;
    base = wr_cnt;
    do_start();
    checks++;
    if ({rx_ready, busy, core_rst_n} !== 3'b110) begin
      errors++;
      $display("FAIL %s_start: rdy/busy/crst=%b want 110", tag,
               {rx_ready, busy, core_rst_n});
    end
    send_word(32'd2);
    send_word(32'h0000_0513);
    checks++;
    if ({imem_we, rx_ready, imem_addr, imem_wdata} !==
        {2'b10, AW'(0), 32'h0000_0513}) begin
      errors++;
      $display("FAIL %s_w0_strobe: we=%b rdy=%b addr=%0d data=%h want 1 0 0 00000513",
               tag, imem_we, rx_ready, imem_addr, imem_wdata);
    end
    send_word(32'h0010_0593);
    checks++;
    if ({imem_we, rx_ready, core_rst_n, imem_addr, imem_wdata} !==
        {3'b100, AW'(1), 32'h0010_0593}) begin
      errors++;
      $display("FAIL %s_w1_strobe: we=%b rdy=%b crst=%b addr=%0d data=%h want 1 0 0 1 00100593",
               tag, imem_we, rx_ready, core_rst_n, imem_addr, imem_wdata);
    end
    rx_valid = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if ({imem_we, done, core_rst_n, busy, err} !== 5'b01100) begin
      errors++;
      $display("FAIL %s_done: we/done/crst/busy/err=%b want 01100", tag,
               {imem_we, done, core_rst_n, busy, err});
    end
    checks++;
    if (wr_cnt - base !== 2 || wr_addr[base] !== AW'(0) ||
        wr_data[base] !== 32'h0000_0513 || wr_addr[base+1] !== AW'(1) ||
        wr_data[base+1] !== 32'h0010_0593) begin
      errors++;
      $display("FAIL %s_writes: n=%0d %0d:%h %0d:%h want 2 0:00000513 1:00100593",
               tag, wr_cnt - base, wr_addr[base], wr_data[base],
               wr_addr[base+1], wr_data[base+1]);
    end
  endtask

  task automatic test_nominal;
    load_two("nominal");
  endtask

  task automatic test_backpressure;
    gaps = 1'b1;
    load_two("gaps");
    gaps = 1'b0;
  endtask

  task automatic test_restart_mid;
    int base;
    base = wr_cnt;
    do_start();
    send_word(32'd2);
    send_byte(8'h13);
    send_byte(8'h05);
    do_start();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL mid_start_busy: busy/done=%b want 10", {busy, done});
    end
    send_byte(8'h00);
    send_byte(8'h00);
    send_word(32'h0010_0593);
    idle(2);
    checks++;
    if (wr_cnt - base !== 2 || wr_data[base] !== 32'h0000_0513 ||
        wr_addr[base+1] !== AW'(1) || wr_data[base+1] !== 32'h0010_0593 ||
        done !== 1'b1) begin
      errors++;
      $display("FAIL mid_start_load: n=%0d d0=%h a1=%0d d1=%h done=%b want 2 00000513 1 00100593 1",
               wr_cnt - base, wr_data[base], wr_addr[base+1],
               wr_data[base+1], done);
    end
  endtask

  task automatic test_start_in_done;
    int base;
    base = wr_cnt;
    do_start();
    checks++;
    if ({core_rst_n, done, busy, rx_ready} !== 4'b0011) begin
      errors++;
      $display("FAIL done_restart: crst/done/busy/rdy=%b want 0011",
               {core_rst_n, done, busy, rx_ready});
    end
    send_word(32'd1);
    send_word(32'hDEAD_BEEF);
    idle(1);
    checks++;
    if (wr_cnt - base !== 1 || wr_addr[base] !== AW'(0) ||
        wr_data[base] !== 32'hDEAD_BEEF || {done, core_rst_n} !== 2'b11) begin
      errors++;
      $display("FAIL reload: n=%0d a=%0d d=%h done/crst=%b want 1 0 deadbeef 11",
               wr_cnt - base, wr_addr[base], wr_data[base], {done, core_rst_n});
    end
  endtask

  task automatic test_zero_len;
    int base;
    base = wr_cnt;
    do_start();
    send_word(32'd0);
    checks++;
    if ({done, core_rst_n, rx_ready, busy, err} !== 5'b11000) begin
      errors++;
      $display("FAIL zero_len_done: done/crst/rdy/busy/err=%b want 11000",
               {done, core_rst_n, rx_ready, busy, err});
    end
    idle(4);
    checks++;
    if (wr_cnt - base !== 0) begin
      errors++;
      $display("FAIL zero_len_writes: got %0d want 0", wr_cnt - base);
    end
  endtask

  task automatic test_oversize;
    int base;
    base = wr_cnt;
    do_start();
    send_word(32'd1025);
    checks++;
    if ({err, done, busy, rx_ready, core_rst_n} !== 5'b10000) begin
      errors++;
      $display("FAIL oversize_err: err/done/busy/rdy/crst=%b want 10000",
               {err, done, busy, rx_ready, core_rst_n});
    end
    idle(6);
    checks++;
    if (wr_cnt - base !== 0 || core_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL oversize_quiet: writes=%0d crst=%b want 0 0",
               wr_cnt - base, core_rst_n);
    end
  endtask

  task automatic test_start_in_err;
    int base;
    base = wr_cnt;
    do_start();
    checks++;
    if ({err, busy} !== 2'b01) begin
      errors++;
      $display("FAIL err_restart: err/busy=%b want 01", {err, busy});
    end
    send_word(32'd1);
    send_word(32'hCAFE_F00D);
    idle(1);
    checks++;
    if (wr_cnt - base !== 1 || wr_addr[base] !== AW'(0) ||
        wr_data[base] !== 32'hCAFE_F00D || {done, core_rst_n, err} !== 3'b110) begin
      errors++;
      $display("FAIL err_retry: n=%0d a=%0d d=%h done/crst/err=%b want 1 0 cafef00d 110",
               wr_cnt - base, wr_addr[base], wr_data[base],
               {done, core_rst_n, err});
    end
  endtask

  task automatic test_full_len;
    int base;
    int bad;
    logic [31:0] w;
    base = wr_cnt;
    bad = 0;
    do_start();
    send_word(32'd1024);
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i) * 32'h0100_0193 + 32'h13;
      send_word(w);
    end
    idle(1);
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i) * 32'h0100_0193 + 32'h13;
      if (wr_addr[(base + i) % 4096] !== AW'(i) ||
          wr_data[(base + i) % 4096] !== w)
        bad++;
    end
    checks++;
    if (wr_cnt - base !== 1024 || bad !== 0) begin
      errors++;
      $display("FAIL full_writes: n=%0d bad=%0d want 1024 0", wr_cnt - base, bad);
    end
    checks++;
    if (wr_addr[(base + 1023) % 4096] !== AW'(1023) ||
        {done, core_rst_n, err} !== 3'b110) begin
      errors++;
      $display("FAIL full_last: addr=%0d done/crst/err=%b want 1023 110",
               wr_addr[(base + 1023) % 4096], {done, core_rst_n, err});
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_restart_mid();
    test_start_in_done();
    test_zero_len();
    test_oversize();
    test_start_in_err();
    test_full_len();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL strobe_shape: violations=%0d want 0", viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
